dvp_rx_frame_monitor: RTL and testbench
=======================================

// Module: dvp_rx_frame_monitor
// PURPOSE
//  Synthesizable DVP receiver at the ISP input. Samples href/vsync/data on pclk and emits a
//  per-pixel stream with sof/eol/eof framing. Measures line width and frame height, and
//  flags deviations from the configured geometry. It is the capture-side counterpart of the
//  DVP source models used in simulation.
// PARAMETERS
//  BITS     8     pixel data width (8/16/24/32)
//  H_DISP   1920  expected active pixels per line
//  V_DISP   1080  expected active lines per frame
//  V_POL    1     vsync active level (1 = active-high pulse)
//  CNT_W    16    width of pixel/line counters and measurement outputs
// PORTS
//  pclk         in   1      pixel clock, sole clock
//  rst_n        in   1      synchronous reset, active-low
//  href         in   1      line-valid; data valid while high
//  vsync        in   1      frame sync, level per V_POL
//  data         in   BITS   pixel data
//  err_clr      in   1      clears sticky error flags
//  out_valid    out  1      out_data holds an accepted pixel
//  out_data     out  BITS   pixel data
//  out_sof      out  1      with out_valid: first pixel of frame
//  out_eol      out  1      with out_valid: pixel H_DISP-1 of line
//  out_eof      out  1      with out_valid: last pixel of line V_DISP-1
//  frame_done   out  1      1-cycle pulse when a frame is closed
//  meas_width   out  CNT_W  pixel count of last completed line
//  meas_height  out  CNT_W  href-line count of last closed frame
//  err_width    out  1      sticky: some line length != H_DISP
//  err_height   out  1      sticky: some frame line count != V_DISP
// BEHAVIOUR
//  - Reset (rst_n low at a pclk edge): all outputs 0. Counters 0. FSM -> SYNC.
//    Reset mid-frame abandons the frame: no frame_done, and no error is raised for it.
//  - Input stage: href/vsync/data registered once (stage 1). The output stage is registered.
//    Latency from input sample to out_* is 2 pclk cycles.
//  - vs_edge is the stage-1 transition of vsync into the V_POL level. It is the only frame delimiter.
//  - FSM:
//      SYNC  : out_valid=0, all input ignored. On vs_edge -> VBLK. The first partial frame after reset is discarded.
//      VBLK  : wait for the first href rise -> ACTIVE, line_cnt=0, pix_cnt=0.
//      ACTIVE: href high: pix_cnt++. out_valid=1 while pix_cnt<H_DISP and line_cnt<V_DISP.
//              href fall: meas_width<=pix_cnt. err_width<=1 if pix_cnt!=H_DISP. line_cnt++, pix_cnt=0.
//              vs_edge -> VBLK (close frame).
//  - Close frame (from ACTIVE on vs_edge): meas_height<=line_cnt. err_height<=1 if line_cnt!=V_DISP.
//    frame_done pulses 1 cycle.
//    vs_edge in VBLK with no lines does not close a frame (no frame_done).
//  - Framing flags:
//      out_sof at pix 0 / line 0.
//      out_eol at pix H_DISP-1 (a short line gets no eol).
//      out_eof = out_eol on line V_DISP-1.
//  - Overlong lines: pixels beyond H_DISP-1 dropped (out_valid=0).
//    Overtall frames: lines >= V_DISP dropped. Errors are flagged at line/frame close as above.
//  - vs_edge while href high: the line is truncated and closed first (width check applies), then the frame closes in the same cycle.
//  - err_clr and a new error in the same cycle: the error flag ends 1 (set wins).
//  - Counters saturate at 2^CNT_W-1. No wrap-around.
// STRUCTURE
//  - Package dvp_pkg:
//      state enum {SYNC, VBLK, ACTIVE}
//      CNT_W default
//      helper function lvl(x, pol) for polarity normalisation
//  - One sub-module, dvp_sync_edge: registers href/vsync with polarity applied and outputs
//    rise/fall pulses (href_rise, href_fall, vs_edge).
//    Counters, FSM and the output stage live in the top.
// TESTING
//  1. BITS=8, 4x3 frames, ramp data 0..11, two frames after a leading partial frame
//     -> first frame discarded; then 12 out_valid per frame, sof on data 0, eol on 3/7/11,
//     eof on 11, frame_done x2, meas 4/3, no errors.
//  2. Line 1 only 3 pixels -> that line has no eol; err_width=1; meas_width=3 after line 1
//     and 4 after line 2; err_height=0.
//  3. Line 0 has 6 pixels -> pixels 4,5 dropped, err_width=1. Frame with 4 lines ->
//     line 3 dropped, meas_height=4, err_height=1.
//  4. rst_n low for 1 cycle mid-line 1 -> outputs 0 next cycle; no frame_done until a full
//     frame follows the next vs_edge.
//  5. err_clr asserted in the same cycle as a short-line href fall -> err_width stays 1.
//     err_clr on an idle cycle -> 0.
//  6. BITS=24, V_POL=0, 2x2 frame -> 2-cycle latency checked per pixel and data matches
//     byte-exact.

Source files
------------

// File: rtl/dvp_pkg.sv
// Shared types and helpers for the DVP receive path.
package dvp_pkg;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        VBLK   = 2'd1,
        ACTIVE = 2'd2
    } dvp_state_e;

    localparam int unsigned CNT_W_DEF = 16;

    // Map a raw sync level onto "1 = asserted" regardless of polarity.
    function automatic logic lvl(input logic x, input logic pol);
        return pol ? x : ~x;
    endfunction

endpackage

// File: rtl/dvp_sync_edge.sv
// Stage-1 input register for the DVP bus plus href/vsync edge detection.
// vsync is normalised so that 1 always means "asserted".
module dvp_sync_edge
    import dvp_pkg::*;
#(
    parameter int unsigned BITS  = 8,
    parameter bit          V_POL = 1'b1
) (
    input  logic            i_pclk,
    input  logic            i_rst_n,
    input  logic            i_href,
    input  logic            i_vsync,
    input  logic [BITS-1:0] i_data,
    output logic            o_href,
    output logic [BITS-1:0] o_data,
    output logic            o_href_rise,
    output logic            o_href_fall,
    output logic            o_vs_edge
);

    logic            r_href;
    logic            r_href_d;
    logic            r_vs;
    logic            r_vs_d;
    logic [BITS-1:0] r_data;

    // Stage-1 capture and one-cycle history for edge detection.
    always_ff @(posedge i_pclk) begin
        if (!i_rst_n) begin
            r_href   <= 1'b0;
            r_href_d <= 1'b0;
            r_vs     <= 1'b0;
            r_vs_d   <= 1'b0;
            r_data   <= '0;
        end else begin
            r_href   <= i_href;
            r_href_d <= r_href;
            r_vs     <= lvl(i_vsync, V_POL);
            r_vs_d   <= r_vs;
            r_data   <= i_data;
        end
    end

    assign o_href      = r_href;
    assign o_data      = r_data;
    assign o_href_rise = r_href & ~r_href_d;
    assign o_href_fall = ~r_href & r_href_d;
    assign o_vs_edge   = r_vs & ~r_vs_d;

endmodule

// File: rtl/dvp_rx_frame_monitor.sv
// DVP capture: framing (sof/eol/eof), line/frame measurement and sticky geometry errors.
module dvp_rx_frame_monitor
    import dvp_pkg::*;
#(
    parameter int unsigned BITS   = 8,
    parameter int unsigned H_DISP = 1920,
    parameter int unsigned V_DISP = 1080,
    parameter bit          V_POL  = 1'b1,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic             i_pclk,
    input  logic             i_rst_n,
    input  logic             i_href,
    input  logic             i_vsync,
    input  logic [BITS-1:0]  i_data,
    input  logic             i_err_clr,
    output logic             o_out_valid,
    output logic [BITS-1:0]  o_out_data,
    output logic             o_out_sof,
    output logic             o_out_eol,
    output logic             o_out_eof,
    output logic             o_frame_done,
    output logic [CNT_W-1:0] o_meas_width,
    output logic [CNT_W-1:0] o_meas_height,
    output logic             o_err_width,
    output logic             o_err_height
);

    localparam logic [CNT_W-1:0] HD    = CNT_W'(H_DISP);
    localparam logic [CNT_W-1:0] VD    = CNT_W'(V_DISP);
    localparam logic [CNT_W-1:0] HD_M1 = CNT_W'(H_DISP - 1);
    localparam logic [CNT_W-1:0] VD_M1 = CNT_W'(V_DISP - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic            w_href;
    logic            w_href_rise;
    logic            w_href_fall;
    logic            w_vs_edge;
    logic [BITS-1:0] w_data;

    dvp_sync_edge #(
        .BITS  (BITS),
        .V_POL (V_POL)
    ) u_sync_edge (
        .i_pclk      (i_pclk),
        .i_rst_n     (i_rst_n),
        .i_href      (i_href),
        .i_vsync     (i_vsync),
        .i_data      (i_data),
        .o_href      (w_href),
        .o_data      (w_data),
        .o_href_rise (w_href_rise),
        .o_href_fall (w_href_fall),
        .o_vs_edge   (w_vs_edge)
    );

    dvp_state_e       r_state;
    dvp_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_pix_cnt;
    logic [CNT_W-1:0] r_line_cnt;
    logic [CNT_W-1:0] w_pix_nxt;
    logic [CNT_W-1:0] w_line_nxt;
    logic             w_take;
    logic [CNT_W-1:0] w_pix_idx;
    logic [CNT_W-1:0] w_line_idx;
    logic             w_line_close;
    logic             w_frame_close;
    logic [CNT_W-1:0] w_lines_total;
    logic             w_valid;
    logic             w_sof;
    logic             w_eol;
    logic             w_eof;

    logic             r_out_valid;
    logic [BITS-1:0]  r_out_data;
    logic             r_out_sof;
    logic             r_out_eol;
    logic             r_out_eof;
    logic             r_frame_done;
    logic [CNT_W-1:0] r_meas_width;
    logic [CNT_W-1:0] r_meas_height;
    logic             r_err_width;
    logic             r_err_height;

    // Next-state, counter updates and per-pixel framing decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_pix_nxt     = r_pix_cnt;
        w_line_nxt    = r_line_cnt;
        w_take        = 1'b0;
        w_pix_idx     = r_pix_cnt;
        w_line_idx    = r_line_cnt;
        w_line_close  = 1'b0;
        w_frame_close = 1'b0;
        w_lines_total = r_line_cnt;
        w_valid       = 1'b0;
        w_sof         = 1'b0;
        w_eol         = 1'b0;
        w_eof         = 1'b0;

        unique case (r_state)
            SYNC: begin
                if (w_vs_edge) w_state_nxt = VBLK;
            end
            VBLK: begin
                // The href rise cycle already carries pixel 0 of line 0.
                if (w_href_rise) begin
                    w_state_nxt = ACTIVE;
                    w_take      = 1'b1;
                    w_pix_idx   = '0;
                    w_line_idx  = '0;
                    w_line_nxt  = '0;
                end
            end
            ACTIVE: begin
                if (w_vs_edge) begin
                    // An open line is truncated (this cycle's pixel dropped) and closed first.
                    w_line_close  = w_href | w_href_fall;
                    w_frame_close = 1'b1;
                    w_state_nxt   = VBLK;
                    w_pix_nxt     = '0;
                    w_line_nxt    = '0;
                end else begin
                    if (w_href_fall) begin
                        w_line_close = 1'b1;
                        w_pix_nxt    = '0;
                        w_line_nxt   = sat_inc(r_line_cnt);
                    end
                    if (w_href) begin
                        w_take = 1'b1;
                    end
                end
            end
            default: w_state_nxt = SYNC;
        endcase

        w_lines_total = w_line_close ? sat_inc(r_line_cnt) : r_line_cnt;

        if (w_take) begin
            w_valid   = (w_pix_idx < HD) && (w_line_idx < VD);
            w_sof     = w_valid && (w_pix_idx == '0) && (w_line_idx == '0);
            w_eol     = w_valid && (w_pix_idx == HD_M1);
            w_eof     = w_eol && (w_line_idx == VD_M1);
            w_pix_nxt = sat_inc(w_pix_idx);
        end
    end

    // State, counters, registered output stage and sticky error flags.
    always_ff @(posedge i_pclk) begin
        if (!i_rst_n) begin
            r_state       <= SYNC;
            r_pix_cnt     <= '0;
            r_line_cnt    <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_sof     <= 1'b0;
            r_out_eol     <= 1'b0;
            r_out_eof     <= 1'b0;
            r_frame_done  <= 1'b0;
            r_meas_width  <= '0;
            r_meas_height <= '0;
            r_err_width   <= 1'b0;
            r_err_height  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pix_cnt    <= w_pix_nxt;
            r_line_cnt   <= w_line_nxt;
            r_out_valid  <= w_valid;
            r_out_sof    <= w_sof;
            r_out_eol    <= w_eol;
            r_out_eof    <= w_eof;
            r_frame_done <= w_frame_close;
            if (w_valid) r_out_data <= w_data;
            if (w_line_close) r_meas_width <= r_pix_cnt;
            if (w_frame_close) r_meas_height <= w_lines_total;
            // A new error beats a simultaneous clear.
            if (w_line_close && (r_pix_cnt != HD)) begin
                r_err_width <= 1'b1;
            end else if (i_err_clr) begin
                r_err_width <= 1'b0;
            end
            if (w_frame_close && (w_lines_total != VD)) begin
                r_err_height <= 1'b1;
            end else if (i_err_clr) begin
                r_err_height <= 1'b0;
            end
        end
    end

    assign o_out_valid   = r_out_valid;
    assign o_out_data    = r_out_data;
    assign o_out_sof     = r_out_sof;
    assign o_out_eol     = r_out_eol;
    assign o_out_eof     = r_out_eof;
    assign o_frame_done  = r_frame_done;
    assign o_meas_width  = r_meas_width;
    assign o_meas_height = r_meas_height;
    assign o_err_width   = r_err_width;
    assign o_err_height  = r_err_height;

endmodule

// File: tb/tb_dvp_rx_frame_monitor.sv
// Directed bench: 4x3 8-bit instance and 2x2 24-bit inverted-vsync instance.
module tb_dvp_rx_frame_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n, err_clr;
    logic        href8, vs8;
    logic [7:0]  data8;
    logic        href24, vs24;
    logic [23:0] data24;

    logic        valid8, sof8, eol8, eof8, fd8, errw8, errh8;
    logic [7:0]  odata8;
    logic [15:0] mw8, mh8;
    logic        valid24, sof24, eol24, eof24, fd24, errw24, errh24;
    logic [23:0] odata24;
    logic [15:0] mw24, mh24;

    dvp_rx_frame_monitor #(
        .BITS(8), .H_DISP(4), .V_DISP(3), .V_POL(1'b1), .CNT_W(16)
    ) u_dut8 (
        .i_pclk(clk), .i_rst_n(rst_n), .i_href(href8), .i_vsync(vs8), .i_data(data8),
        .i_err_clr(err_clr), .o_out_valid(valid8), .o_out_data(odata8), .o_out_sof(sof8),
        .o_out_eol(eol8), .o_out_eof(eof8), .o_frame_done(fd8), .o_meas_width(mw8),
        .o_meas_height(mh8), .o_err_width(errw8), .o_err_height(errh8)
    );

    dvp_rx_frame_monitor #(
        .BITS(24), .H_DISP(2), .V_DISP(2), .V_POL(1'b0), .CNT_W(16)
    ) u_dut24 (
        .i_pclk(clk), .i_rst_n(rst_n), .i_href(href24), .i_vsync(vs24), .i_data(data24),
        .i_err_clr(1'b0), .o_out_valid(valid24), .o_out_data(odata24), .o_out_sof(sof24),
        .o_out_eol(eol24), .o_out_eof(eof24), .o_frame_done(fd24), .o_meas_width(mw24),
        .o_meas_height(mh24), .o_err_width(errw24), .o_err_height(errh24)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Log of accepted pixels from the 8-bit instance: data and {sof,eol,eof}.
    int         q_data[$];
    logic [2:0] q_flag[$];
    int         fd_cnt = 0;

    always @(negedge clk) begin
        if (valid8) begin
            q_data.push_back(int'(odata8));
            q_flag.push_back({sof8, eol8, eof8});
        end
        if (fd8) fd_cnt++;
    end

    // 24-bit instance: expected pixels and the cycle each was driven.
    logic [23:0] exp24 [4];
    int          drv_cyc [4];
    int          idx24 = 0;
    int          fd24_cnt = 0;

    always @(negedge clk) begin
        if (fd24) fd24_cnt++;
        if (valid24) begin
            if (idx24 < 4) begin
                check("data24", 32'(odata24), 32'(exp24[idx24]));
                check("lat24", 32'(cyc - drv_cyc[idx24]), 32'd2);
                check("flags24", {29'd0, sof24, eol24, eof24},
                      {29'd0, idx24 == 0, idx24 % 2 == 1, idx24 == 3});
            end else begin
                check("extra24", 32'(idx24), 32'd3);
            end
            idx24++;
        end
    end

    task automatic idle8(input int n);
        repeat (n) begin
            @(negedge clk);
            href8 = 1'b0; vs8 = 1'b0; data8 = 8'd0;
        end
    endtask

    task automatic vs_pulse8();
        repeat (2) begin
            @(negedge clk);
            href8 = 1'b0; vs8 = 1'b1;
        end
        idle8(2);
    endtask

    task automatic line8(input int w, input int base);
        for (int i = 0; i < w; i++) begin
            @(negedge clk);
            href8 = 1'b1; vs8 = 1'b0; data8 = 8'(base + i);
        end
        idle8(3);
    endtask

    task automatic clear_log();
        q_data.delete();
        q_flag.delete();
        fd_cnt = 0;
    endtask

    task automatic err_clr_pulse();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    int n_eol;
    int n_eof;

    initial begin
        exp24[0] = 24'hA1B2C3; exp24[1] = 24'h00FF00;
        exp24[2] = 24'h123456; exp24[3] = 24'hFEDCBA;
        rst_n = 1'b0; err_clr = 1'b0;
        href8 = 1'b0; vs8 = 1'b0; data8 = 8'd0;
        href24 = 1'b0; vs24 = 1'b1; data24 = 24'd0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(valid8), 32'd0);
        check("rst_fd", 32'(fd8), 32'd0);
        check("rst_mw", 32'(mw8), 32'd0);
        check("rst_mh", 32'(mh8), 32'd0);
        check("rst_err", {30'd0, errw8, errh8}, 32'd0);
        rst_n = 1'b1;
        idle8(2);

        // 1: leading partial frame discarded, then two clean 4x3 frames.
        line8(4, 0);
        line8(4, 4);
        vs_pulse8();
        for (int f = 0; f < 2; f++) begin
            line8(4, 0); line8(4, 4); line8(4, 8);
            vs_pulse8();
        end
        idle8(2);
        check("t1_count", 32'(q_data.size()), 32'd24);
        for (int i = 0; i < 24 && i < q_data.size(); i++) begin
            check($sformatf("t1_data%0d", i), 32'(q_data[i]), 32'(i % 12));
            check($sformatf("t1_flag%0d", i), {29'd0, q_flag[i]},
                  {29'd0, (i % 12) == 0, (i % 4) == 3, (i % 12) == 11});
        end
        check("t1_fd", 32'(fd_cnt), 32'd2);
        check("t1_mw", 32'(mw8), 32'd4);
        check("t1_mh", 32'(mh8), 32'd3);
        check("t1_err", {30'd0, errw8, errh8}, 32'd0);

        // 2: short line 1.
        clear_log();
        line8(4, 0);
        line8(3, 4);
        check("t2_mw1", 32'(mw8), 32'd3);
        check("t2_errw", 32'(errw8), 32'd1);
        line8(4, 7);
        check("t2_mw2", 32'(mw8), 32'd4);
        vs_pulse8();
        idle8(1);
        n_eol = 0; n_eof = 0;
        foreach (q_flag[i]) begin
            n_eol += int'(q_flag[i][1]);
            n_eof += int'(q_flag[i][0]);
        end
        check("t2_count", 32'(q_data.size()), 32'd11);
        check("t2_eols", 32'(n_eol), 32'd2);
        check("t2_eofs", 32'(n_eof), 32'd1);
        check("t2_errh", 32'(errh8), 32'd0);
        check("t2_mh", 32'(mh8), 32'd3);
        check("t2_fd", 32'(fd_cnt), 32'd1);
        err_clr_pulse();
        check("t2_clr", 32'(errw8), 32'd0);

        // 3: overlong line 0 and a 4-line frame.
        clear_log();
        line8(6, 0); line8(4, 6); line8(4, 10); line8(4, 14);
        vs_pulse8();
        idle8(1);
        check("t3_count", 32'(q_data.size()), 32'd12);
        if (q_data.size() == 12) begin
            check("t3_skip", 32'(q_data[4]), 32'd6);
            check("t3_last", 32'(q_data[11]), 32'd13);
            check("t3_eof", {29'd0, q_flag[11]}, 32'b011);
        end
        check("t3_errw", 32'(errw8), 32'd1);
        check("t3_mh", 32'(mh8), 32'd4);
        check("t3_errh", 32'(errh8), 32'd1);
        err_clr_pulse();
        check("t3_clr", {30'd0, errw8, errh8}, 32'd0);

        // 4: reset in the middle of line 1.
        line8(4, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            href8 = 1'b1; data8 = 8'(4 + i);
        end
        @(negedge clk);
        rst_n = 1'b0; data8 = 8'd6;
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        check("t4_valid", 32'(valid8), 32'd0);
        check("t4_mw", 32'(mw8), 32'd0);
        check("t4_mh", 32'(mh8), 32'd0);
        href8 = 1'b1; data8 = 8'd7;
        idle8(3);
        vs_pulse8();
        idle8(2);
        check("t4_nofd", 32'(fd_cnt), 32'd0);
        check("t4_nopix", 32'(q_data.size()), 32'd0);
        line8(4, 0); line8(4, 4); line8(4, 8);
        vs_pulse8();
        idle8(1);
        check("t4_fd", 32'(fd_cnt), 32'd1);
        check("t4_count", 32'(q_data.size()), 32'd12);
        check("t4_err", {30'd0, errw8, errh8}, 32'd0);

        // 5: clear coinciding with a short-line close; set must win.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            href8 = 1'b1; data8 = 8'(i);
        end
        @(negedge clk);
        href8 = 1'b0; err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        idle8(1);
        check("t5_setwins", 32'(errw8), 32'd1);
        check("t5_mw", 32'(mw8), 32'd3);
        line8(4, 3); line8(4, 7);
        vs_pulse8();
        err_clr_pulse();
        check("t5_clr", {30'd0, errw8, errh8}, 32'd0);

        // 6: 24-bit, active-low vsync, 2x2 frame.
        repeat (2) begin
            @(negedge clk);
            vs24 = 1'b0;
        end
        @(negedge clk);
        vs24 = 1'b1;
        repeat (2) @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < 2; p++) begin
                @(negedge clk);
                href24 = 1'b1;
                data24 = exp24[l * 2 + p];
                drv_cyc[l * 2 + p] = cyc;
            end
            @(negedge clk);
            href24 = 1'b0; data24 = 24'd0;
            repeat (2) @(negedge clk);
        end
        repeat (2) begin
            @(negedge clk);
            vs24 = 1'b0;
        end
        @(negedge clk);
        vs24 = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_count", 32'(idx24), 32'd4);
        check("t6_fd", 32'(fd24_cnt), 32'd1);
        check("t6_mw", 32'(mw24), 32'd2);
        check("t6_mh", 32'(mh24), 32'd2);
        check("t6_err", {30'd0, errw24, errh24}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
